// File: rtl/ppu_pkg.sv
// Shared PPU constants: color/palette widths and palette address layout.
package ppu_pkg;
    localparam int COLOR_W       = 24;
    localparam int PAL_AW        = 5;
    // Address bit that selects the sprite half of the palette
    localparam int SPR_ADDR_BIT  = 4;
    // Palette entry shown where no layer is opaque
    localparam int BACKDROP_ADDR = 0;
endpackage

// File: rtl/ppu_pixel_mux.sv
// PPU pixel mux: forms background/sprite palette addresses, chooses the
// visible layer by priority, and outputs RGB with delay-matched DE/syncs.
// The palette RAM sits outside this block and has one cycle of read latency.
module ppu_pixel_mux
    import ppu_pkg::*;
#(
    parameter int COLOR_W = ppu_pkg::COLOR_W,
    parameter int PAL_AW  = ppu_pkg::PAL_AW
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               render_en,
    input  logic               pix_valid,
    input  logic               hsync_in,
    input  logic               vsync_in,
    input  logic               frame_start,
    input  logic [1:0]         bg_pal,
    input  logic [1:0]         bg_px,
    input  logic [1:0]         spr_pal,
    input  logic [1:0]         spr_px,
    input  logic               spr_behind,
    input  logic               spr_zero,
    output logic [PAL_AW-1:0]  pal_addr_a,
    output logic [PAL_AW-1:0]  pal_addr_b,
    output logic               palette_en,
    input  logic [COLOR_W-1:0] color_a,
    input  logic [COLOR_W-1:0] color_b,
    output logic [COLOR_W-1:0] rgb_out,
    output logic               de_out,
    output logic               hsync_out,
    output logic               vsync_out,
    output logic               spr0_hit
);

    logic bg_opaque;
    logic spr_opaque;
    logic sel_spr;
    logic hit_now;

    // Stage-1 pipeline registers, aligned with palette read data
    logic s1_sel_spr;
    logic s1_valid;
    logic s1_hsync;
    logic s1_vsync;
    logic s1_render;

    assign bg_opaque  = (bg_px != 2'd0);
    assign spr_opaque = (spr_px != 2'd0);
    assign sel_spr    = spr_opaque && (!spr_behind || !bg_opaque);
    assign hit_now    = pix_valid && render_en && spr_zero && spr_opaque && bg_opaque;
    assign palette_en = render_en;

    // Palette addresses; transparent background falls back to the backdrop entry
    always_comb begin
        pal_addr_a = PAL_AW'(BACKDROP_ADDR);
        if (bg_opaque)
            pal_addr_a = PAL_AW'({bg_pal, bg_px});
        pal_addr_b = PAL_AW'(1 << SPR_ADDR_BIT) | PAL_AW'({spr_pal, spr_px});
    end

    // Stage 1: capture layer choice and timing flags while the palette is read
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_sel_spr <= 1'b0;
            s1_valid   <= 1'b0;
            s1_hsync   <= 1'b0;
            s1_vsync   <= 1'b0;
            s1_render  <= 1'b0;
        end else begin
            s1_sel_spr <= sel_spr;
            s1_valid   <= pix_valid;
            s1_hsync   <= hsync_in;
            s1_vsync   <= vsync_in;
            s1_render  <= render_en;
        end
    end

    // Stage 2: pick palette data; blank when not rendering or outside active video
    always_ff @(posedge clk) begin
        if (rst) begin
            rgb_out   <= '0;
            de_out    <= 1'b0;
            hsync_out <= 1'b0;
            vsync_out <= 1'b0;
        end else begin
            rgb_out   <= (s1_render && s1_valid) ? (s1_sel_spr ? color_b : color_a) : '0;
            de_out    <= s1_valid;
            hsync_out <= s1_hsync;
            vsync_out <= s1_vsync;
        end
    end

    // Sticky sprite-0 hit; a hit in the frame_start cycle keeps it set
    always_ff @(posedge clk) begin
        if (rst)
            spr0_hit <= 1'b0;
        else if (hit_now)
            spr0_hit <= 1'b1;
        else if (frame_start)
            spr0_hit <= 1'b0;
    end

endmodule

// File: tb/tb_ppu_pixel_mux.sv
// Self-checking bench for ppu_pixel_mux: directed cases plus random pixels
// against a reference model that works straight from palette contents.
module tb_ppu_pixel_mux;

    logic        clk = 1'b0;
    logic        rst;
    logic        render_en, pix_valid, hsync_in, vsync_in, frame_start;
    logic [1:0]  bg_pal, bg_px, spr_pal, spr_px;
    logic        spr_behind, spr_zero;
    logic [4:0]  pal_addr_a, pal_addr_b;
    logic        palette_en;
    logic [23:0] color_a, color_b, rgb_out;
    logic        de_out, hsync_out, vsync_out, spr0_hit;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [23:0] rgb;
        logic        de;
        logic        hs;
        logic        vs;
    } pix_t;

    pix_t        exp_q[$];
    logic [23:0] pal[32];
    logic        exp_hit;

    always #5 clk = ~clk;

    // Palette RAM beside the DUT: one-cycle read latency
    always @(posedge clk) begin
        color_a <= pal[pal_addr_a];
        color_b <= pal[pal_addr_b];
    end

    ppu_pixel_mux dut (
        .clk(clk), .rst(rst), .render_en(render_en), .pix_valid(pix_valid),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .frame_start(frame_start),
        .bg_pal(bg_pal), .bg_px(bg_px), .spr_pal(spr_pal), .spr_px(spr_px),
        .spr_behind(spr_behind), .spr_zero(spr_zero),
        .pal_addr_a(pal_addr_a), .pal_addr_b(pal_addr_b), .palette_en(palette_en),
        .color_a(color_a), .color_b(color_b), .rgb_out(rgb_out),
        .de_out(de_out), .hsync_out(hsync_out), .vsync_out(vsync_out),
        .spr0_hit(spr0_hit)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One pixel clock: check addresses, predict the pixel, clock, check outputs
    task automatic cyc();
        int   a_idx, b_idx;
        logic use_spr, hit;
        pix_t p, o;
        #1;
        a_idx = (bg_px != 0) ? (bg_pal * 4 + bg_px) : 0;
        b_idx = 16 + spr_pal * 4 + spr_px;
        chk("pal_addr_a", 32'(pal_addr_a), 32'(a_idx));
        chk("pal_addr_b", 32'(pal_addr_b), 32'(b_idx));
        chk("palette_en", 32'(palette_en), 32'(render_en));
        use_spr = (spr_px != 0) && (!spr_behind || bg_px == 0);
        p.rgb = (render_en && pix_valid) ? (use_spr ? pal[b_idx] : pal[a_idx]) : 24'h0;
        p.de  = pix_valid;
        p.hs  = hsync_in;
        p.vs  = vsync_in;
        hit   = pix_valid && render_en && spr_zero && spr_px != 0 && bg_px != 0;
        if (rst) begin
            // Reset wipes the pixel already in flight as well as this one
            p = '{24'h0, 1'b0, 1'b0, 1'b0};
            if (exp_q.size() > 0) exp_q[exp_q.size()-1] = p;
            exp_hit = 1'b0;
        end else if (hit) exp_hit = 1'b1;
        else if (frame_start) exp_hit = 1'b0;
        exp_q.push_back(p);
        @(posedge clk);
        #1;
        chk("spr0_hit", 32'(spr0_hit), 32'(exp_hit));
        if (exp_q.size() >= 2) begin
            o = exp_q.pop_front();
            chk("rgb_out", 32'(rgb_out), 32'(o.rgb));
            chk("de_out", 32'(de_out), 32'(o.de));
            chk("hsync_out", 32'(hsync_out), 32'(o.hs));
            chk("vsync_out", 32'(vsync_out), 32'(o.vs));
        end
    endtask

    task automatic set_px(input logic [1:0] bp, input logic [1:0] bx,
                          input logic [1:0] sp, input logic [1:0] sx,
                          input logic beh, input logic s0);
        bg_pal = bp; bg_px = bx; spr_pal = sp; spr_px = sx;
        spr_behind = beh; spr_zero = s0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) pal[i] = 24'($urandom);
        pal[0]  = 24'h9df732;
        pal[3]  = 24'hf23535;
        pal[6]  = 24'h339ab8;
        pal[17] = 24'h0000ff;
        exp_hit = 1'b0;
        rst = 1'b1; render_en = 1'b1; pix_valid = 1'b1;
        hsync_in = 1'b0; vsync_in = 1'b0; frame_start = 1'b0;
        set_px(2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0);
        repeat (3) cyc();
        chk("reset_rgb", 32'(rgb_out), 32'h0);
        chk("reset_de", 32'(de_out), 32'h0);
        chk("reset_hit", 32'(spr0_hit), 32'h0);
        rst = 1'b0;

        // Background only, palette 1 entry 2
        set_px(2'd1, 2'd2, 2'd0, 2'd0, 1'b0, 1'b0);
        repeat (3) cyc();
        chk("bg_rgb", 32'(rgb_out), 32'h339ab8);
        chk("bg_de", 32'(de_out), 32'h1);

        // Sprite in front of background
        set_px(2'd0, 2'd3, 2'd0, 2'd1, 1'b0, 1'b0);
        repeat (3) cyc();
        chk("spr_front_rgb", 32'(rgb_out), 32'h0000ff);

        // Sprite behind opaque background
        spr_behind = 1'b1;
        repeat (3) cyc();
        chk("spr_behind_rgb", 32'(rgb_out), 32'hf23535);

        // Both transparent -> backdrop, then rendering disabled
        set_px(2'd2, 2'd0, 2'd1, 2'd0, 1'b0, 1'b0);
        repeat (3) cyc();
        chk("backdrop_rgb", 32'(rgb_out), 32'h9df732);
        render_en = 1'b0;
        cyc();
        chk("render_off_lat1", 32'(rgb_out), 32'h9df732);
        cyc();
        chk("render_off_rgb", 32'(rgb_out), 32'h0);
        render_en = 1'b1;

        // Sprite-0 hit, sticky, then frame_start with simultaneous hit
        set_px(2'd0, 2'd1, 2'd0, 2'd2, 1'b1, 1'b1);
        cyc();
        chk("s0_set", 32'(spr0_hit), 32'h1);
        set_px(2'd0, 2'd1, 2'd0, 2'd0, 1'b0, 1'b0);
        repeat (4) cyc();
        chk("s0_hold", 32'(spr0_hit), 32'h1);
        set_px(2'd0, 2'd1, 2'd0, 2'd2, 1'b1, 1'b1);
        frame_start = 1'b1;
        cyc();
        chk("s0_fs_set_wins", 32'(spr0_hit), 32'h1);
        set_px(2'd0, 2'd1, 2'd0, 2'd0, 1'b0, 1'b0);
        cyc();
        chk("s0_fs_clear", 32'(spr0_hit), 32'h0);
        frame_start = 1'b0;

        // 640-pixel line with toggling hsync and random pixels
        for (int i = 0; i < 640; i++) begin
            hsync_in = 1'($urandom);
            set_px(2'($urandom), 2'($urandom), 2'($urandom), 2'($urandom),
                   1'($urandom), 1'($urandom));
            cyc();
        end

        // Fully random traffic including resets, blanking and frame starts
        for (int i = 0; i < 3000; i++) begin
            rst         = ($urandom_range(0, 49) == 0);
            render_en   = ($urandom_range(0, 9) != 0);
            pix_valid   = ($urandom_range(0, 7) != 0);
            hsync_in    = 1'($urandom);
            vsync_in    = 1'($urandom);
            frame_start = ($urandom_range(0, 19) == 0);
            set_px(2'($urandom), 2'($urandom), 2'($urandom), 2'($urandom),
                   1'($urandom), 1'($urandom));
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ppu_pixel_mux.md
PPU_PIXEL_MUX -- requirements
Module: ppu_pixel_mux

Interface
REQ-001 SHALL have parameter COLOR_W, default 24: RGB width.
REQ-002 SHALL have parameter PAL_AW, default 5: palette address width.
REQ-003 SHALL have port clk, input, 1: single clock; all logic on posedge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port render_en, input, 1: rendering enable; drives palette_en.
REQ-006 SHALL have ports pix_valid, hsync_in, vsync_in, input, 1 each: active-video flag and syncs for the current pixel.
REQ-007 SHALL have port frame_start, input, 1: one-cycle pulse at frame start.
REQ-008 SHALL have ports bg_pal and bg_px, input, 2 each: background palette select and color index.
REQ-009 SHALL have ports spr_pal and spr_px, input, 2 each: sprite palette select and color index.
REQ-010 SHALL have ports spr_behind and spr_zero, input, 1 each: sprite-behind-background priority bit and sprite-0 flag.
REQ-011 SHALL have ports pal_addr_a and pal_addr_b, output, PAL_AW each: background and sprite palette addresses.
REQ-012 SHALL have port palette_en, output, 1: palette read enable.
REQ-013 SHALL have ports color_a and color_b, input, COLOR_W each: palette read data, valid one cycle after the address.
REQ-014 SHALL have port rgb_out, output, COLOR_W: final pixel color.
REQ-015 SHALL have ports de_out, hsync_out, vsync_out, output, 1 each: delay-matched data-enable and syncs.
REQ-016 SHALL have port spr0_hit, output, 1: sticky sprite-0 hit flag.

Function
REQ-017 SHALL drive pal_addr_a combinationally: {0,bg_pal,bg_px} when bg_px!=0, else 0 (backdrop).
REQ-018 SHALL drive pal_addr_b combinationally: {1,spr_pal,spr_px}.
REQ-019 SHALL drive palette_en = render_en, combinationally.
REQ-020 SHALL register at input edge N (stage 1): sel_spr = spr_px!=0 && (!spr_behind || bg_px==0), plus pix_valid, hsync_in, vsync_in and render_en.
REQ-021 SHALL register at edge N+1 (stage 2): rgb_out = stage-1 render_en && pix_valid ? (sel_spr ? color_b : color_a) : 0.
REQ-022 SHALL register at edge N+1: de_out, hsync_out and vsync_out from stage 1, giving a fixed latency of 2 cycles with syncs aligned to rgb_out.
REQ-023 SHALL cover both-transparent pixels via REQ-017: output is backdrop entry 0 from color_a.
REQ-024 SHALL set spr0_hit at edge N when pix_valid && render_en && spr_zero && spr_px!=0 && bg_px!=0, regardless of spr_behind.
REQ-025 SHALL clear spr0_hit on a frame_start edge; a same-cycle hit condition SHALL set it (set wins).
REQ-026 SHALL take effect for a render_en change on the pixel presented that cycle, 2-cycle latency like the data.
REQ-027 SHALL have no back-pressure: one pixel per clock continuously, with no bubbles inserted.

Reset
REQ-028 SHALL, while rst=1, reset rgb_out=0, de_out=0, hsync_out=0, vsync_out=0, spr0_hit=0, and all stage-1 registers to 0.
REQ-029 SHALL not clear palette_en or pal_addr_a/b on reset (combinational outputs).
REQ-030 SHALL, on reset asserted mid-line, make output black with de_out=0 from the next edge; first valid output is 2 cycles after release.

Structure
REQ-031 SHALL place in a shared ppu package: COLOR_W, PAL_AW, the sprite-half address bit position (4), and BACKDROP_ADDR=0.
REQ-032 SHALL be implemented flat, with no sub-module; the palette RAM is instantiated beside this block, not inside it.

Verification
REQ-033 SHALL cover: rst pulse, then bg_pal=1, bg_px=2, spr_px=0, pix_valid=1 -> pal_addr_a=6 and rgb_out=24'h339ab8 two cycles later, de_out=1.
REQ-034 SHALL cover: bg_px=3 (pal0), spr_pal=0, spr_px=1, spr_behind=0 -> pal_addr_b=17 and rgb_out=24'h0000FF.
REQ-035 SHALL cover: same as REQ-034 but spr_behind=1 -> rgb_out=24'hf23535 (bg entry 3).
REQ-036 SHALL cover: bg_px=0, spr_px=0 -> rgb_out=24'h9df732 (backdrop); then render_en=0 -> rgb_out=0 after 2 cycles.
REQ-037 SHALL cover: spr_zero=1, spr_px=2, bg_px=1, spr_behind=1 -> spr0_hit=1 next cycle and held until frame_start; frame_start with a simultaneous hit -> stays 1.
REQ-038 SHALL cover: 640-pixel line with toggling hsync_in -> hsync_out equals hsync_in delayed exactly 2 cycles, with no dropped pixels.
